// File: rtl/aes_pkg.sv
// Shared AES definitions: FSM state encoding, block/column geometry and GF(2^8) helpers.
// Used by inv_mix_columns_ctrl and inv_mix_column_col.
package aes_pkg;

    localparam int AES_BLK_W = 128;
    localparam int AES_COL_W = 32;
    localparam int NUM_COLS  = 4;

    localparam logic [7:0] XTIME_POLY = 8'h1b;

    // Matrix first rows, one nibble per coefficient, leftmost multiplies byte 0.
    localparam logic [15:0] INV_ROW0 = 16'hebd9;
    localparam logic [15:0] FWD_ROW0 = 16'h2311;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        COL  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? XTIME_POLY : 8'h00);
    endfunction

    // Multiply by a 4-bit constant as a sum of b, 2b, 4b, 8b.
    function automatic logic [7:0] gf_mul(input logic [7:0] b, input logic [3:0] k);
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return (k[0] ? b : 8'h00) ^ (k[1] ? x2 : 8'h00) ^
               (k[2] ? x4 : 8'h00) ^ (k[3] ? x8 : 8'h00);
    endfunction

endpackage

// File: rtl/inv_mix_column_col.sv
// Combinational (Inv)MixColumns on one 32-bit column; byte 0 is the MSB.
// With INV_MIX_COLUMNS_CTRL_FWD_EN defined, i_fwd=1 selects the forward matrix.
module inv_mix_column_col
    import aes_pkg::*;
(
    input  logic [AES_COL_W-1:0] i_col,
`ifdef INV_MIX_COLUMNS_CTRL_FWD_EN
    input  logic                 i_fwd,
`endif
    output logic [AES_COL_W-1:0] o_col
);

    // Circulant product: output row r uses coefficient row0[(j - r) mod 4] for byte j.
    function automatic logic [AES_COL_W-1:0] mix_col(input logic [AES_COL_W-1:0] col,
                                                     input logic [15:0]          row0);
        logic [7:0]           a [NUM_COLS];
        logic [3:0]           k [NUM_COLS];
        logic [7:0]           acc;
        logic [AES_COL_W-1:0] res;
        res = '0;
        for (int j = 0; j < NUM_COLS; j++) begin
            a[j] = col[AES_COL_W-1-8*j -: 8];
            k[j] = row0[15-4*j -: 4];
        end
        for (int r = 0; r < NUM_COLS; r++) begin
            acc = 8'h00;
            for (int j = 0; j < NUM_COLS; j++) begin
                acc = acc ^ gf_mul(a[j], k[2'(j - r)]);
            end
            res[AES_COL_W-1-8*r -: 8] = acc;
        end
        return res;
    endfunction

    logic [15:0] w_row0;

    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
        w_row0 = INV_ROW0;
`ifdef INV_MIX_COLUMNS_CTRL_FWD_EN
        if (i_fwd) begin
            w_row0 = FWD_ROW0;
        end
`endif
        o_col = mix_col(i_col, w_row0);
    end

endmodule

// File: rtl/inv_mix_columns_ctrl.sv
// Column-serial AES InvMixColumns engine: one shared column unit, IDLE/COL/DONE handshake FSM.
// Optional INV_MIX_COLUMNS_CTRL_FWD_EN adds in_fwd to select the forward MixColumns matrix.
module inv_mix_columns_ctrl
    import aes_pkg::*;
#(
    parameter int TAG_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [AES_BLK_W-1:0] in_data,
    input  logic                 in_bypass,
    input  logic [TAG_W-1:0]     in_tag,
`ifdef INV_MIX_COLUMNS_CTRL_FWD_EN
    input  logic                 in_fwd,
`endif
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [AES_BLK_W-1:0] out_data,
    output logic [TAG_W-1:0]     out_tag,
    output logic                 busy
);

    state_t               r_state;
    logic [1:0]           r_col;
    logic [AES_BLK_W-1:0] r_data;
    logic [TAG_W-1:0]     r_tag;
    logic                 r_in_ready;
    logic                 r_out_valid;
    logic                 r_busy;
`ifdef INV_MIX_COLUMNS_CTRL_FWD_EN
    logic                 r_fwd;
`endif

    logic [AES_COL_W-1:0] w_col_in;
    logic [AES_COL_W-1:0] w_col_out;

    always_comb begin
        w_col_in = r_data[AES_BLK_W-1 -: AES_COL_W];
        for (int c = 0; c < NUM_COLS; c++) begin
            if (r_col == 2'(c)) begin
                w_col_in = r_data[AES_BLK_W-1-AES_COL_W*c -: AES_COL_W];
            end
        end
    end

    inv_mix_column_col u_col (
        .i_col (w_col_in),
`ifdef INV_MIX_COLUMNS_CTRL_FWD_EN
        .i_fwd (r_fwd),
`endif
        .o_col (w_col_out)
    );

    // The result is built in place: each column is read once and overwritten by its mix.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_col       <= 2'd0;
            r_data      <= '0;
            r_tag       <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
`ifdef INV_MIX_COLUMNS_CTRL_FWD_EN
            r_fwd       <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_data     <= in_data;
                        r_tag      <= in_tag;
                        r_col      <= 2'd0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= in_bypass ? DONE : COL;
`ifdef INV_MIX_COLUMNS_CTRL_FWD_EN
                        r_fwd      <= in_fwd;
`endif
                    end else begin
                        r_in_ready <= 1'b1;
                    end
                end
                COL: begin
                    for (int c = 0; c < NUM_COLS; c++) begin
                        if (r_col == 2'(c)) begin
                            r_data[AES_BLK_W-1-AES_COL_W*c -: AES_COL_W] <= w_col_out;
                        end
                    end
                    r_col <= r_col + 2'd1;
                    if (r_col == 2'(NUM_COLS - 1)) begin
                        r_state     <= DONE;
                        r_out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    // A bypass block enters DONE unpresented and raises out_valid one edge later.
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_data;
    assign out_tag   = r_tag;
    assign busy      = r_busy;

endmodule

// File: tb/tb_inv_mix_columns_ctrl.sv
// Directed, table-driven bench for inv_mix_columns_ctrl: data, tag, latency, stall and reset.
// Define INV_MIX_COLUMNS_CTRL_FWD_EN to also exercise the forward-matrix path.
module tb_inv_mix_columns_ctrl;

    localparam int TAG_W = 4;

    typedef struct {
        logic [127:0]     data;
        logic             bypass;
        logic [TAG_W-1:0] tag;
        logic [127:0]     exp;
    } vec_t;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [127:0]     in_data;
    logic             in_bypass;
    logic [TAG_W-1:0] in_tag;
`ifdef INV_MIX_COLUMNS_CTRL_FWD_EN
    logic             in_fwd;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [127:0]     out_data;
    logic [TAG_W-1:0] out_tag;
    logic             busy;

    int checks = 0;
    int errors = 0;

    vec_t vecs [8];

    inv_mix_columns_ctrl #(.TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_bypass (in_bypass),
        .in_tag    (in_tag),
`ifdef INV_MIX_COLUMNS_CTRL_FWD_EN
        .in_fwd    (in_fwd),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (in_ready !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("in_ready_wait", 128'(in_ready), 128'(1));
    endtask

    task automatic run_block(input vec_t v, input int idx);
        int lat = 0;
        wait_ready();
        in_valid  = 1'b1;
        in_data   = v.data;
        in_bypass = v.bypass;
        in_tag    = v.tag;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        in_data   = ~v.data;
        in_bypass = ~v.bypass;
        check($sformatf("v%0d_busy", idx), 128'(busy), 128'(1));
        check($sformatf("v%0d_ready_low", idx), 128'(in_ready), 128'(0));
        while (out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check($sformatf("v%0d_latency", idx), 128'(lat), v.bypass ? 128'(1) : 128'(4));
        check($sformatf("v%0d_data", idx), out_data, v.exp);
        check($sformatf("v%0d_tag", idx), 128'(out_tag), 128'(v.tag));
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check($sformatf("v%0d_valid_drop", idx), 128'(out_valid), 128'(0));
        check($sformatf("v%0d_ready_back", idx), 128'(in_ready), 128'(1));
        check($sformatf("v%0d_idle", idx), 128'(busy), 128'(0));
    endtask

    initial begin
        int lat;

        vecs[0] = '{{4{32'h8e4da1bc}}, 1'b0, 4'h1, {4{32'hdb135345}}};
        vecs[1] = '{{4{32'h9fdc589d}}, 1'b0, 4'h2, {4{32'hf20a225c}}};
        vecs[2] = '{{16{8'h01}},       1'b0, 4'h3, {16{8'h01}}};
        vecs[3] = '{{16{8'hc6}},       1'b0, 4'h4, {16{8'hc6}}};
        vecs[4] = '{128'h00112233445566778899aabbccddeeff, 1'b1, 4'ha,
                    128'h00112233445566778899aabbccddeeff};
        vecs[5] = '{{32'h8e4da1bc, 32'h9fdc589d, 32'h01010101, 32'hc6c6c6c6}, 1'b0, 4'h6,
                    {32'hdb135345, 32'hf20a225c, 32'h01010101, 32'hc6c6c6c6}};
        vecs[6] = '{{4{32'h8e4da1bc}}, 1'b1, 4'h7, {4{32'h8e4da1bc}}};
        vecs[7] = '{{32'hc6c6c6c6, 32'h01010101, 32'h9fdc589d, 32'h8e4da1bc}, 1'b0, 4'hf,
                    {32'hc6c6c6c6, 32'h01010101, 32'hf20a225c, 32'hdb135345}};

        rst       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_bypass = 1'b0;
        in_tag    = '0;
        out_ready = 1'b0;
`ifdef INV_MIX_COLUMNS_CTRL_FWD_EN
        in_fwd    = 1'b0;
`endif
        #2;
        check("rst_in_ready", 128'(in_ready), 128'(0));
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_out_data", out_data, 128'(0));
        check("rst_out_tag", 128'(out_tag), 128'(0));
        #10;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_ready", 128'(in_ready), 128'(1));

        for (int i = 0; i < 8; i++) begin
            run_block(vecs[i], i);
        end

        // Output stall: a second block is offered while DONE waits on out_ready.
        wait_ready();
        in_valid  = 1'b1;
        in_data   = vecs[0].data;
        in_bypass = 1'b0;
        in_tag    = 4'h5;
        @(posedge clk);
        #1;
        in_data = vecs[1].data;
        in_tag  = 4'h9;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("stall_latency", 128'(lat), 128'(4));
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("stall_data_%0d", i), out_data, vecs[0].exp);
            check($sformatf("stall_ready_%0d", i), 128'(in_ready), 128'(0));
            check($sformatf("stall_valid_%0d", i), 128'(out_valid), 128'(1));
        end
        check("stall_tag", 128'(out_tag), 128'(4'h5));
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("stall_release_ready", 128'(in_ready), 128'(1));
        @(posedge clk);
        #1;
        check("stall_no_second", 128'(busy), 128'(0));

        // Reset while the column counter sits at 2.
        wait_ready();
        in_valid  = 1'b1;
        in_data   = vecs[0].data;
        in_bypass = 1'b0;
        in_tag    = 4'h3;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("midrst_valid", 128'(out_valid), 128'(0));
        check("midrst_ready", 128'(in_ready), 128'(0));
        check("midrst_busy", 128'(busy), 128'(0));
        check("midrst_data", out_data, 128'(0));
        check("midrst_tag", 128'(out_tag), 128'(0));
        @(posedge clk);
        #1;
        check("midrst_hold_valid", 128'(out_valid), 128'(0));
        check("midrst_hold_ready", 128'(in_ready), 128'(0));
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_ready_back", 128'(in_ready), 128'(1));
        check("midrst_idle", 128'(busy), 128'(0));
        run_block(vecs[1], 11);

`ifdef INV_MIX_COLUMNS_CTRL_FWD_EN
        in_fwd = 1'b1;
        run_block('{{4{32'hdb135345}}, 1'b0, 4'hc, {4{32'h8e4da1bc}}}, 12);
        in_fwd = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
